// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg: shared pipeline types for the instruction fetch unit.
//   XLEN            datapath / PC width
//   decode_signals  {instr, curr_pc, inc_pc} bundle handed to the decoder
//   ifu_state_e     fetch FSM state (RUN / FLUSH)
// ---------------------------------------------------------------------------
package ifu_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] curr_pc;
        logic [XLEN-1:0] inc_pc;
    } decode_signals;

    // RUN: every response is kept. FLUSH: stale responses are still owed.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo: synchronous FIFO of DEPTH entries of type T (DEPTH power of two).
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i/data_i   write an entry (accepted when not full, or full with pop)
//   pop_i           drop the head entry (ignored when empty)
//   flush_i         empty the FIFO; overrides push and pop in the same cycle
//   head_o          head entry, all-zero while empty
//   full_o/empty_o  occupancy flags
//   count_o         number of stored entries
// ---------------------------------------------------------------------------
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter type T      = decode_signals,
    parameter int  DEPTH  = 2,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  T              data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output T              head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    T              mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    // Zero the head while empty so the consumer never sees stale contents.
    always_comb begin
        head_o = '0;
        if (!empty_o) begin
            head_o = mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head_o is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu: instruction fetch unit feeding the decoder.
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr word fetch request channel
//   imem_rsp_valid, imem_rsp_data   in-order response channel
//   redirect_valid, redirect_pc     PC change from execute
//   signals_out, out_valid/ready    {instr, curr_pc, inc_pc} to decode
//   dbg_state_o                     current fetch FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid does not depend on ready of the same channel, and a
// request, once valid, keeps its address until accepted or redirected.
// ---------------------------------------------------------------------------
module ifu
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output decode_signals   signals_out,
    output logic            out_valid,
    input  logic            out_ready,
    output ifu_state_e      dbg_state_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic            active_q;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    ifu_state_e      state_q, state_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic            req_fire, push, pop;
    logic [CW:0]     occupancy;
    logic [XLEN-1:0] redirect_tgt;
    decode_signals   push_data;

    // Misaligned redirect targets are silently rounded down to a word.
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

    // A redirect flushes the FIFO, so a pop in that cycle does not happen.
    assign pop = out_valid && out_ready && !redirect_valid;

    // Credit counts the entry leaving the FIFO this cycle as already free,
    // which lets a DEPTH=2 buffer sustain one instruction per cycle. The
    // registered sum still never exceeds DEPTH.
    assign occupancy = (CW+1)'(outstanding_q) + (CW+1)'(fifo_count) - (CW+1)'(pop);

    // active_q keeps the request channel quiet while reset is applied.
    assign imem_req_valid = active_q && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // In FLUSH every arriving response is stale; in the redirect cycle the
    // arriving response belongs to the old path as well.
    assign push = imem_rsp_valid && (state_q == RUN) && !redirect_valid;

    always_comb begin
        push_data.instr   = imem_rsp_data;
        push_data.curr_pc = rsp_pc_q;
        push_data.inc_pc  = rsp_pc_q + XLEN'(4);
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        state_d       = state_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            // Every request still in flight after this cycle is stale.
            drop_d     = outstanding_q - CW'(imem_rsp_valid);
            state_d    = (drop_d != '0) ? FLUSH : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (imem_rsp_valid) rsp_pc_d = rsp_pc_q + XLEN'(4);
                end
                FLUSH: begin
                    if (imem_rsp_valid) begin
                        drop_d = drop_q - CW'(1);
                        if (drop_q == CW'(1)) state_d = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q      <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            state_q       <= RUN;
        end else begin
            active_q      <= 1'b1;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            state_q       <= state_d;
        end
    end

    ifu_fifo #(
        .T     (decode_signals),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .head_o  (signals_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid   = !fifo_empty;
    assign dbg_state_o = state_q;

    a_credit: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, outstanding_q} + {1'b0, fifo_count}) <= (CW+1)'(DEPTH));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

    a_state_drop: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == FLUSH) == (drop_q != '0));

endmodule

// File: tb/tb_ifu.sv
`timescale 1ns/1ps
module tb_ifu;
  import ifu_pkg::*;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic          imem_req_valid, imem_req_ready;
  logic [31:0]   imem_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  decode_signals signals_out;
  logic          out_valid, out_ready;
  ifu_state_e    dbg_state;

  ifu #(.RESET_PC(32'h0), .DEPTH(DEPTH)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .signals_out    (signals_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- wrap-around DUT (RESET_PC near the top) ----------------
  logic          w_req_valid;
  logic [31:0]   w_addr;
  logic          w_rsp_valid;
  logic [31:0]   w_rsp_data;
  decode_signals w_sig;
  logic          w_out_valid;
  ifu_state_e    w_state;

  ifu #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) u_dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (1'b1),
    .imem_addr      (w_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .signals_out    (w_sig),
    .out_valid      (w_out_valid),
    .out_ready      (1'b1),
    .dbg_state_o    (w_state)
  );

  // ---------------- bookkeeping ----------------
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int deliveries  = 0;
  int accepts     = 0;
  int first_valid_cyc = -1;
  bit log_accepts = 1'b0;
  int accept_cycles[$];

  // stimulus knobs
  int ready_pct = 100;
  int req_pct   = 100;
  int lat_min   = 1;
  int lat_max   = 1;
  int mem_mode  = 0;

  // reference model: the architectural fetch stream
  logic [31:0] exp_req_pc;
  logic [31:0] stream_pc;
  logic [95:0] exp_q[$];

  // memory model: in-order pending responses
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend_q[$];
  int    last_due = 0;

  bit          hold_chk  = 1'b0;
  logic [31:0] hold_addr = '0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_mode == 0) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic refill();
    while (exp_q.size() < 32) begin
      exp_q.push_back({mem_word(stream_pc), stream_pc, stream_pc + 32'd4});
      stream_pc += 32'd4;
    end
  endtask

  // Start a new delivery stream at a word-aligned target.
  task automatic restart_stream(input logic [31:0] tgt);
    exp_q.delete();
    exp_req_pc = {tgt[31:2], 2'b00};
    stream_pc  = {tgt[31:2], 2'b00};
    refill();
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic rv, input logic [31:0] rpc);
    int d;
    @(negedge clk);
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = ($urandom_range(99) < ready_pct);
    imem_req_ready = ($urandom_range(99) < req_pct);
    #1;
    if (hold_chk && !rv) check("req_addr_hold", imem_addr, hold_addr);
    hold_chk  = imem_req_valid && !imem_req_ready;
    hold_addr = imem_addr;
    if (rv) begin
      check("no_req_on_redirect", imem_req_valid, 1'b0);
      hold_chk = 1'b0;
      restart_stream(rpc);
    end else if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_addr, exp_req_pc);
      exp_req_pc += 32'd4;
      accepts++;
      if (log_accepts) accept_cycles.push_back(cyc);
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend_q.push_back('{addr: imem_addr, due: d});
      check("outstanding_le_depth", (pend_q.size() <= DEPTH), 1'b1);
    end
    refill();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 1'b0);
    check({tag, "_addr"},      imem_addr, 32'h0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_signals"},   signals_out, 96'h0);
    check({tag, "_state"},     dbg_state, RUN);
  endtask

  // Asynchronous reset pulse in the middle of a cycle; memory resets too.
  task automatic pulse_reset();
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    imem_req_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    pend_q.delete();
    last_due = cyc;
    hold_chk = 1'b0;
    restart_stream(32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic redirect_and_check(input logic [31:0] tgt);
    int stale;
    step(1'b1, tgt);
    stale = pend_q.size();
    step(1'b0, 32'h0);
    check("state_after_redirect", dbg_state, (stale > 0) ? FLUSH : RUN);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [95:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (rst_n && out_valid && out_ready && !redirect_valid) begin
        deliveries++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL deliver: got %0h with no expected entry", signals_out);
        end else begin
          exp = exp_q.pop_front();
          check("deliver", signals_out, exp);
        end
      end
    end
  end

  // ---------------- wrap-around instance ----------------
  logic [31:0] w_addrs[$];
  initial begin : wrap_check
    bit pend = 1'b0;
    bit got  = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_data  = '0;
    wait (rst_n === 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      w_rsp_valid = pend;
      w_rsp_data  = 32'h0000_0013;
      #1;
      pend = w_req_valid;
      if (w_req_valid) w_addrs.push_back(w_addr);
      if (w_out_valid && !got) begin
        got = 1'b1;
        check("wrap_curr_pc", w_sig.curr_pc, WRAP_PC);
        check("wrap_inc_pc",  w_sig.inc_pc, 32'h0);
        check("wrap_instr",   w_sig.instr, 32'h13);
      end
    end
    w_rsp_valid = 1'b0;
    check("wrap_delivered", got, 1'b1);
    check("wrap_req_count_ge2", (w_addrs.size() >= 2), 1'b1);
    if (w_addrs.size() >= 2) begin
      check("wrap_addr0", w_addrs[0], WRAP_PC);
      check("wrap_addr1", w_addrs[1], 32'h0);
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time budget exceeded at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int d0;
    int a0;
    int stale;
    int guard;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    restart_stream(32'h0);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Phase 1: 1-cycle memory, decode always ready.
    log_accepts = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h0);
    check("req_valid_first_cycle", imem_req_valid, 1'b1);
    run(9);
    d0 = deliveries;
    run(30);
    check("throughput_1_per_cycle", deliveries - d0, 30);
    log_accepts = 1'b0;
    check("accept_log_size", (accept_cycles.size() >= 3), 1'b1);
    if (accept_cycles.size() >= 3) begin
      check("consecutive_req1", accept_cycles[1] - accept_cycles[0], 1);
      check("consecutive_req2", accept_cycles[2] - accept_cycles[0], 2);
      check("first_out_latency", first_valid_cyc - accept_cycles[0], 2);
    end

    // Phase 2: backpressure from decode.
    ready_pct = 0;
    pulse_reset();
    a0 = accepts;
    run(10);
    check("backpressure_accepts", accepts - a0, 2);
    check("backpressure_req_valid", imem_req_valid, 1'b0);
    check("backpressure_out_valid", out_valid, 1'b1);
    ready_pct = 100;
    a0 = accepts;
    d0 = deliveries;
    run(10);
    check("resume_fetch", (accepts > a0), 1'b1);
    check("resume_deliver", (deliveries - d0 >= 2), 1'b1);

    // Reset with the FIFO full.
    ready_pct = 0;
    run(8);
    check("full_before_reset", out_valid, 1'b1);
    pulse_reset();
    ready_pct = 100;
    run(6);

    // Phase 3: 3-cycle memory, redirect with requests in flight.
    lat_min = 3;
    lat_max = 3;
    run(10);
    d0 = deliveries;
    redirect_and_check(32'h100);
    run(20);
    check("progress_after_redirect", (deliveries > d0), 1'b1);

    // Phase 4: redirect coinciding with a response, misaligned target.
    lat_min = 1;
    lat_max = 1;
    run(6);
    guard = 0;
    while (!(pend_q.size() > 0 && pend_q[0].due == cyc + 1) && guard < 20) begin
      step(1'b0, 32'h0);
      guard++;
    end
    check("rsp_aligned_setup", (guard < 20), 1'b1);
    redirect_and_check(32'h203);
    run(10);

    // Phase 5: back-to-back redirects; the later target wins.
    lat_min = 2;
    lat_max = 2;
    run(6);
    step(1'b1, 32'h40);
    step(1'b1, 32'h80);
    stale = pend_q.size();
    step(1'b0, 32'h0);
    check("state_after_double_redirect", dbg_state, (stale > 0) ? FLUSH : RUN);
    d0 = deliveries;
    run(20);
    check("progress_after_double_redirect", (deliveries > d0), 1'b1);

    // Phase 6: randomized traffic, redirects and handshakes.
    mem_mode  = 1;
    ready_pct = 70;
    req_pct   = 70;
    lat_min   = 1;
    lat_max   = 4;
    step(1'b1, 32'h1000);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 4) step(1'b1, $urandom());
      else step(1'b0, 32'h0);
    end
    ready_pct = 100;
    req_pct   = 100;
    d0 = deliveries;
    run(20);
    check("progress_final", (deliveries > d0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
